// File: rtl/bcd_mod60_counter_pkg.sv
// Shared constants and helpers for the two-digit BCD counter.
//   DIGIT_W   : width of one BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   CLR_VAL   : two-digit value after clear
//   bcd_legal : checks a digit against an inclusive maximum
package bcd_mod60_counter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 2 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [COUNT_W-1:0] CLR_VAL = 8'h00;

  // True when digit does not exceed max_val.
  function automatic logic bcd_legal(input logic [DIGIT_W-1:0] digit,
                                     input logic [DIGIT_W-1:0] max_val);
    return digit <= max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One synchronous 4-bit catalog-style counter digit that wraps at MAX.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous active-high clear (highest priority)
//   load : synchronous parallel preset from data
//   p, t : count enables; only t gates rco
//   data : preset value
//   q    : current digit
//   rco  : ripple carry, t & (q == MAX), combinational
module bcd_digit_cell
  import bcd_mod60_counter_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_MAX
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               p,
  input  logic               t,
  input  logic [DIGIT_W-1:0] data,
  output logic [DIGIT_W-1:0] q,
  output logic               rco
);

  logic at_max_c;

  assign at_max_c = (q == MAX);
  assign rco      = t & at_max_c;

  // Priority: clear > load > count > hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (p && t) begin
      q <= at_max_c ? '0 : DIGIT_W'(q + 4'd1);
    end
  end

endmodule

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD modulo-(TENS_MOD*10) counter built from two cascaded
// digit cells; ones carry enables the tens digit on the same edge.
// Parameters:
//   TENS_MOD : number of tens states (1..10); wraps after {TENS_MOD-1, 9}
// Ports:
//   CLK   : rising-edge clock
//   CLR   : synchronous active-high clear of count and ERR
//   P, T  : count enables; T also gates RCO
//   LOAD  : synchronous preset from data when data is legal BCD in range
//   data  : preset value, [7:4] tens, [3:0] ones
//   Qdata : current count, [7:4] tens, [3:0] ones
//   RCO   : T & terminal count, combinational
//   ERR   : sticky illegal-load flag, registered
module bcd_mod60_counter
  import bcd_mod60_counter_pkg::*;
#(
  parameter int unsigned TENS_MOD = 6
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         P,
  input  logic         T,
  input  logic         LOAD,
  input  logic [7:0]   data,
  output logic [7:0]   Qdata,
  output logic         RCO,
  output logic         ERR
);

  localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(TENS_MOD - 1);

  logic               load_legal_c;
  logic               load_ok_c;
  logic               cnt_p_c;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] tens_q;
  logic               ones_rco;
  logic               tens_rco;

  assign load_legal_c = bcd_legal(data[DIGIT_W-1:0], BCD_MAX) &
                        bcd_legal(data[COUNT_W-1:DIGIT_W], TENS_MAX);
  assign load_ok_c    = LOAD & load_legal_c;

  // Any LOAD, legal or not, suppresses counting; P does not feed RCO,
  // so gating it here leaves the carry chain untouched.
  assign cnt_p_c = P & ~LOAD;

  bcd_digit_cell #(
    .MAX (BCD_MAX)
  ) u_ones (
    .clk  (CLK),
    .clr  (CLR),
    .load (load_ok_c),
    .p    (cnt_p_c),
    .t    (T),
    .data (data[DIGIT_W-1:0]),
    .q    (ones_q),
    .rco  (ones_rco)
  );

  // Tens T is the ones carry, giving enable = P & T & ones_at_9.
  bcd_digit_cell #(
    .MAX (TENS_MAX)
  ) u_tens (
    .clk  (CLK),
    .clr  (CLR),
    .load (load_ok_c),
    .p    (cnt_p_c),
    .t    (ones_rco),
    .data (data[COUNT_W-1:DIGIT_W]),
    .q    (tens_q),
    .rco  (tens_rco)
  );

  assign Qdata = {tens_q, ones_q};
  assign RCO   = tens_rco;

  // Sticky illegal-load flag, cleared only by CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ERR <= 1'b0;
    end else if (LOAD && !load_legal_c) begin
      ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_mod60_counter.sv
// Randomized plus directed bench for bcd_mod60_counter. Two instances
// (TENS_MOD=6 and 10) share stimulus; each is checked against an
// integer-valued reference model.
module tb_bcd_mod60_counter;

  logic       clk;
  logic       clr, p, t, load;
  logic [7:0] data;
  logic [7:0] q6, q10;
  logic       rco6, rco10, err6, err10;

  int total = 0;
  int bad   = 0;

  int tm [2]  = '{6, 10};
  int n  [2];
  bit e  [2];
  bit known = 1'b0;

  bcd_mod60_counter #(.TENS_MOD(6)) dut6 (
    .CLK(clk), .CLR(clr), .P(p), .T(t), .LOAD(load), .data(data),
    .Qdata(q6), .RCO(rco6), .ERR(err6)
  );

  bcd_mod60_counter #(.TENS_MOD(10)) dut10 (
    .CLK(clk), .CLR(clr), .P(p), .T(t), .LOAD(load), .data(data),
    .Qdata(q10), .RCO(rco10), .ERR(err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Apply one cycle of inputs, check RCO before the edge and state after.
  task automatic step(input bit c, input bit l, input bit pp, input bit tt, input logic [7:0] d);
    int hi, lo;
    @(negedge clk);
    clr = c; load = l; p = pp; t = tt; data = d;
    #1;
    if (known) begin
      check("rco6",  {7'd0, rco6},  {7'd0, (tt && n[0] == tm[0] * 10 - 1)});
      check("rco10", {7'd0, rco10}, {7'd0, (tt && n[1] == tm[1] * 10 - 1)});
    end
    @(posedge clk);
    #1;
    hi = int'(d[7:4]);
    lo = int'(d[3:0]);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        n[k] = 0;
        e[k] = 1'b0;
      end else if (l) begin
        if (lo <= 9 && hi < tm[k]) n[k] = hi * 10 + lo;
        else e[k] = 1'b1;
      end else if (pp && tt) begin
        n[k] = (n[k] + 1) % (tm[k] * 10);
      end
    end
    if (c) known = 1'b1;
    if (known) begin
      check("q6",    q6,  to_bcd(n[0]));
      check("q10",   q10, to_bcd(n[1]));
      check("err6",  {7'd0, err6},  {7'd0, e[0]});
      check("err10", {7'd0, err10}, {7'd0, e[1]});
    end
  endtask

  task automatic count(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 1, 1, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    clr = 1'b1; load = 1'b0; p = 1'b0; t = 1'b0; data = 8'h00;

    // Reset and a full mod-60 pass.
    step(1, 0, 0, 0, 8'h00);
    check("rst_rco6", {7'd0, rco6}, 8'd0);
    count(60);

    // Load 58 then count across the wrap.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h58);
    count(3);

    // Hold at 59 with T low, then with only P low.
    step(0, 1, 0, 0, 8'h59);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 8'h00);
    check("hold59", q6, 8'h59);

    // Illegal loads set ERR; a legal load keeps it; CLR clears it.
    step(0, 1, 1, 1, 8'h3A);
    step(0, 1, 1, 1, 8'h60);
    step(0, 1, 0, 0, 8'h12);
    check("err_sticky", {7'd0, err6}, 8'd1);
    step(1, 0, 0, 0, 8'h00);

    // LOAD+CLR together, then CLR mid-count.
    step(0, 1, 0, 0, 8'h27);
    step(1, 1, 1, 1, 8'h45);
    check("clr_wins", q6, 8'h00);
    count(33);
    check("at33", q6, 8'h33);
    step(1, 0, 1, 1, 8'h00);
    count(2);

    // Multi-cycle LOAD holds value.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'h41);

    // Full mod-100 pass for the TENS_MOD=10 instance.
    step(1, 0, 0, 0, 8'h00);
    count(100);
    check("wrap10", q10, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1)) d = {4'($urandom_range(9)), 4'($urandom_range(9))};
      else d = 8'($urandom);
      step($urandom_range(63) == 0, $urandom_range(9) == 0,
           $urandom_range(7) != 0, $urandom_range(7) != 0, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_mod60_counter.md
# bcd_mod60_counter

Two-digit BCD modulo-N counter (default 00–59) built by cascading two synchronous 4-bit catalog-style counter cells. The ones-digit ripple-carry feeds the tens-digit enable. The block sits directly downstream of the 4-bit catalog counter in the lab7 datapath and consumes its P/T/RCO chaining scheme. It is the seconds/minutes stage of the lab timer, and its RCO feeds the next timer stage.

## Interface

Parameters:
- TENS_MOD, default 6: number of tens states. The counter wraps after {TENS_MOD-1, 9}. Legal range 1–10.

Ports:
- CLK  in  1  rising-edge clock; the only clock in the block.
- CLR  in  1  reset. Synchronous and active-high. Clears count and error flag.
- P  in  1  count enable; does not gate RCO.
- T  in  1  count enable; also gates RCO.
- LOAD  in  1  synchronous parallel preset from data.
- data  in  8  preset value: [7:4] tens BCD, [3:0] ones BCD.
- Qdata  out  8  current count: [7:4] tens, [3:0] ones.
- RCO  out  1  ripple carry: T & (Qdata == {TENS_MOD-1, 4'd9}). Combinational.
- ERR  out  1  sticky illegal-load flag. Registered.

## Operation

- Priority per CLK edge: CLR > LOAD > count > hold.
- CLR=1: Qdata←8'h00, ERR←0. LOAD, P and T are ignored.
- LOAD=1 with legal data (ones ≤ 9 and tens ≤ TENS_MOD-1): Qdata←data. P and T are ignored.
- LOAD=1 with illegal data: Qdata holds and ERR←1. Legal and illegal loads do not count.
- Count (P=1 & T=1, no CLR/LOAD):
  - Ones < 9: ones+1, tens holds.
  - Ones = 9: ones←0 and tens advances.
  - Tens at TENS_MOD-1 with ones = 9: Qdata←8'h00 (wrap).
- P=0 or T=0: hold.
- RCO is high only in the terminal state with T=1. P has no effect on RCO, matching catalog-counter cascading.
- ERR stays set until CLR. A later legal load does not clear it.
- Qdata never leaves the legal BCD range. No reachable state has ones > 9 or tens ≥ TENS_MOD.

## Timing

- Values after a CLR edge: Qdata=8'h00, ERR=0, RCO=0 (the state is non-terminal).
- Before the first CLR, all register state is undefined. The bench must apply CLR in the first cycle.
- Latency is one cycle. Load, count and clear are visible on Qdata immediately after the active CLK edge.
- RCO is combinational from state and T, with no added register. It follows T within the same cycle. It asserts in the same cycle that Qdata reaches the terminal value.
- Tens-cell enable = P & T & ones_RCO. The tens digit advances on the same edge as the ones wrap, with no extra cycle of skew.
- CLR asserted mid-count: the count is aborted on that edge and counting resumes from 00 on the first edge after CLR drops.
- LOAD held for multiple cycles: each edge reloads, so Qdata stays at data and no counting occurs.
- LOAD and CLR together: CLR wins.

## Structure

- Shared package/include file holds:
  - BCD_MAX = 4'd9
  - DIGIT_W = 4
  - the 8'h00 clear value
  - the legality-check function for a BCD digit against a max value
- One sub-module, bcd_digit_cell:
  - 4-bit synchronous counter with CLR, LOAD, P, T, data and Q ports.
  - A parameter MAX sets the wrap point.
  - RCO = T & (Q == MAX).
- Top level holds:
  - two instances of bcd_digit_cell (ones with MAX=9, tens with MAX=TENS_MOD-1);
  - the load-legality check;
  - the ERR register;
  - the top-level RCO output.

## Test plan

- CLR, then P=T=1 for 60 cycles. Required: Qdata steps 00,01…09,10…59,00; RCO=1 only in the 59 cycle; ERR stays 0.
- CLR, then LOAD data=8'h58 for one cycle, then count. Required: Qdata=58 → 59 (RCO=1) → 00 (RCO=0) → 01.
- At Qdata=8'h59, drop T for 3 cycles, then drop only P. Required: with T=0, Qdata holds and RCO=0. With P=0/T=1, Qdata holds at 59 and RCO=1.
- LOAD data=8'h3A, then separately LOAD data=8'h60. Required: for each, Qdata is unchanged and ERR=1. After a legal LOAD 8'h12, Qdata=12 and ERR remains 1. After CLR, ERR=0.
- LOAD=1 and CLR=1 together at Qdata=8'h27 with data=8'h45. Required: Qdata=00. Then assert CLR during a count sequence at Qdata=8'h33; required: Qdata=00 on that edge.
- Instance with TENS_MOD=10. Required: the count reaches 99 with RCO=1, then wraps to 00.
